ps2_scancode_decoder: RTL and testbench

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

---
 rtl/ps2_scancode_decoder.sv | 194 +++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: turns the raw byte stream into make/break events
// with an extended-key flag and queues them in a small event FIFO.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       ck,
    input  logic       reset,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_rel,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [4:0] evt_count,
    output logic       proto_err,
    output logic       ovf
);

    localparam int             PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int             TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]     DEPTH_CNT = 5'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        SKIP    = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic [2:0]      skip_cnt_reg, skip_cnt_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            err_next;
    logic            push_req;
    logic [9:0]      push_data;

    // Event word layout: {ext, rel, code}
    logic [9:0]       mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [4:0]       count_reg;
    logic             proto_err_reg;
    logic             ovf_reg;
    logic             fifo_full, do_push, do_pop;
    logic [9:0]       head;

    always_ff @(posedge ck) begin
        if (reset) begin
            state_reg     <= IDLE;
            skip_cnt_reg  <= '0;
            to_cnt_reg    <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            skip_cnt_reg  <= skip_cnt_next;
            to_cnt_reg    <= to_cnt_next;
            proto_err_reg <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        skip_cnt_next = skip_cnt_reg;
        to_cnt_next   = to_cnt_reg;
        err_next      = 1'b0;
        push_req      = 1'b0;
        push_data     = '0;
        if (in_valid) begin
            to_cnt_next = '0;
            case (state_reg)
                IDLE: begin
                    case (in_byte)
                        8'hE0: state_next = EXT;
                        8'hF0: state_next = BRK;
                        8'hE1: begin
                            state_next    = SKIP;
                            skip_cnt_next = 3'd7;
                        end
                        8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
                        8'h00, 8'hFF: err_next = 1'b1;
                        default: begin
                            push_req  = 1'b1;
                            push_data = {2'b00, in_byte};
                        end
                    endcase
                end
                EXT: begin
                    case (in_byte)
                        8'hF0: state_next = EXT_BRK;
                        8'hE0: state_next = EXT;
                        8'hE1: begin
                            state_next    = SKIP;
                            skip_cnt_next = 3'd7;
                        end
                        // Fake-shift bytes wrapped around extended keys carry no meaning
                        8'h12, 8'h59: state_next = IDLE;
                        default: begin
                            state_next = IDLE;
                            push_req   = 1'b1;
                            push_data  = {2'b10, in_byte};
                        end
                    endcase
                end
                BRK: begin
                    state_next = IDLE;
                    case (in_byte)
                        8'hE0, 8'hF0, 8'hE1: err_next = 1'b1;
                        default: begin
                            push_req  = 1'b1;
                            push_data = {2'b01, in_byte};
                        end
                    endcase
                end
                EXT_BRK: begin
                    state_next = IDLE;
                    case (in_byte)
                        8'h12, 8'h59: ;
                        8'hE0, 8'hF0, 8'hE1: err_next = 1'b1;
                        default: begin
                            push_req  = 1'b1;
                            push_data = {2'b11, in_byte};
                        end
                    endcase
                end
                SKIP: begin
                    if (skip_cnt_reg <= 3'd1) begin
                        state_next    = IDLE;
                        skip_cnt_next = '0;
                    end else begin
                        skip_cnt_next = skip_cnt_reg - 3'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (state_reg != IDLE) begin
            if (to_cnt_reg == TO_LAST) begin
                state_next    = IDLE;
                skip_cnt_next = '0;
                to_cnt_next   = '0;
                err_next      = 1'b1;
            end else begin
                to_cnt_next = to_cnt_reg + 1'b1;
            end
        end
    end

    assign fifo_full = (count_reg == DEPTH_CNT);
    assign do_pop    = (count_reg != 5'd0) && evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push   = push_req && (!fifo_full || do_pop);

    always_ff @(posedge ck) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 5'd1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 5'd1;
            end
            if (push_req && !do_push) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign head      = mem_reg[rd_ptr_reg];
    assign evt_valid = (count_reg != 5'd0);
    assign evt_code  = evt_valid ? head[7:0] : 8'h00;
    assign evt_rel   = evt_valid ? head[8] : 1'b0;
    assign evt_ext   = evt_valid ? head[9] : 1'b0;
    assign evt_count = count_reg;
    assign proto_err = proto_err_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: a byte/expected-event table plus
// hand-written sequences for timeout, FIFO full/overflow and reset.
module tb_ps2_scancode_decoder;

    logic       ck = 1'b0;
    logic       reset;
    logic [7:0] in_byte;
    logic       in_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_rel;
    logic       evt_valid;
    logic       evt_ready;
    logic [4:0] evt_count;
    logic       proto_err;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    ps2_scancode_decoder #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .ck        (ck),
        .reset     (reset),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_rel   (evt_rel),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_count (evt_count),
        .proto_err (proto_err),
        .ovf       (ovf)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [7:0] b;
        logic       v;
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] b, input logic v, input logic [7:0] code,
                       input logic ext, input logic rel, input logic err);
        vec_t t;
        t.b = b; t.v = v; t.code = code; t.ext = ext; t.rel = rel; t.err = err;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Strobes one byte; returns at the falling edge after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge ck);
        in_byte  = b;
        in_valid = 1'b1;
        @(negedge ck);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] evt_word();
        return {21'd0, evt_valid, evt_ext, evt_rel, evt_code};
    endfunction

    function automatic logic [31:0] mk(input logic v, input logic e, input logic r, input logic [7:0] c);
        return {21'd0, v, e, r, c};
    endfunction

    initial begin
        int pulses;
        logic [7:0] q [4];

        reset = 1'b1; in_byte = 8'h00; in_valid = 1'b0; evt_ready = 1'b1;
        repeat (3) @(negedge ck);
        reset = 1'b0;
        @(negedge ck);

        check("reset_evt", evt_word(), mk(1'b0, 1'b0, 1'b0, 8'h00));
        check("reset_count", 32'(evt_count), 32'd0);
        check("reset_flags", {30'd0, proto_err, ovf}, 32'd0);

        add(8'h1C, 1, 8'h1C, 0, 0, 0);
        add(8'hF0, 0, 8'h00, 0, 0, 0);
        add(8'h1C, 1, 8'h1C, 0, 1, 0);
        add(8'hE0, 0, 8'h00, 0, 0, 0);
        add(8'h75, 1, 8'h75, 1, 0, 0);
        add(8'hE0, 0, 8'h00, 0, 0, 0);
        add(8'hF0, 0, 8'h00, 0, 0, 0);
        add(8'h75, 1, 8'h75, 1, 1, 0);
        add(8'hE0, 0, 8'h00, 0, 0, 0);
        add(8'h12, 0, 8'h00, 0, 0, 0);
        add(8'h1C, 1, 8'h1C, 0, 0, 0);
        add(8'hE1, 0, 8'h00, 0, 0, 0);
        add(8'h14, 0, 8'h00, 0, 0, 0);
        add(8'h77, 0, 8'h00, 0, 0, 0);
        add(8'hE1, 0, 8'h00, 0, 0, 0);
        add(8'hF0, 0, 8'h00, 0, 0, 0);
        add(8'h14, 0, 8'h00, 0, 0, 0);
        add(8'hF0, 0, 8'h00, 0, 0, 0);
        add(8'h77, 0, 8'h00, 0, 0, 0);
        add(8'h1C, 1, 8'h1C, 0, 0, 0);
        add(8'h00, 0, 8'h00, 0, 0, 1);
        add(8'hFF, 0, 8'h00, 0, 0, 1);
        add(8'hAA, 0, 8'h00, 0, 0, 0);
        add(8'hF0, 0, 8'h00, 0, 0, 0);
        add(8'hE0, 0, 8'h00, 0, 0, 1);
        add(8'h1C, 1, 8'h1C, 0, 0, 0);
        add(8'hE0, 0, 8'h00, 0, 0, 0);
        add(8'hF0, 0, 8'h00, 0, 0, 0);
        add(8'hF0, 0, 8'h00, 0, 0, 1);
        add(8'hE0, 0, 8'h00, 0, 0, 0);
        add(8'hE0, 0, 8'h00, 0, 0, 0);
        add(8'h6B, 1, 8'h6B, 1, 0, 0);
        add(8'hE0, 0, 8'h00, 0, 0, 0);
        add(8'hF0, 0, 8'h00, 0, 0, 0);
        add(8'h59, 0, 8'h00, 0, 0, 0);
        add(8'h29, 1, 8'h29, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            send_byte(vecs[i].b);
            check($sformatf("vec%0d_evt_%02h", i, vecs[i].b), evt_word(),
                  mk(vecs[i].v, vecs[i].ext, vecs[i].rel, vecs[i].code));
            check($sformatf("vec%0d_err", i), {31'd0, proto_err}, {31'd0, vecs[i].err});
        end

        // Timeout after a dangling E0 prefix
        send_byte(8'hE0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge ck);
            if (proto_err) pulses++;
        end
        check("timeout_early", 32'(pulses), 32'd0);
        for (int i = 0; i < 30; i++) begin
            @(negedge ck);
            if (proto_err) pulses++;
        end
        check("timeout_pulses", 32'(pulses), 32'd1);
        send_byte(8'h1C);
        check("after_timeout_evt", evt_word(), mk(1'b1, 1'b0, 1'b0, 8'h1C));

        // Fill past capacity with the consumer stalled
        @(negedge ck);
        evt_ready = 1'b0;
        send_byte(8'h15);
        send_byte(8'h1D);
        send_byte(8'h24);
        send_byte(8'h2D);
        check("full_ovf_clear", {31'd0, ovf}, 32'd0);
        send_byte(8'h2C);
        check("full_count", 32'(evt_count), 32'd4);
        check("full_ovf", {31'd0, ovf}, 32'd1);
        check("full_head", evt_word(), mk(1'b1, 1'b0, 1'b0, 8'h15));

        q[0] = 8'h15; q[1] = 8'h1D; q[2] = 8'h24; q[3] = 8'h2D;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_head", i), evt_word(), mk(1'b1, 1'b0, 1'b0, q[i]));
            check($sformatf("drain%0d_count", i), 32'(evt_count), 32'(4 - i));
            evt_ready = 1'b1;
            @(negedge ck);
            evt_ready = 1'b0;
        end
        check("drained_evt", evt_word(), mk(1'b0, 1'b0, 1'b0, 8'h00));
        check("drained_count", 32'(evt_count), 32'd0);

        // Refill, then push and pop in the same cycle while full
        send_byte(8'h16);
        send_byte(8'h1E);
        send_byte(8'h26);
        send_byte(8'h25);
        @(negedge ck);
        in_byte = 8'h4C; in_valid = 1'b1; evt_ready = 1'b1;
        @(negedge ck);
        in_valid = 1'b0; evt_ready = 1'b0;
        check("pushpop_count", 32'(evt_count), 32'd4);
        q[0] = 8'h1E; q[1] = 8'h26; q[2] = 8'h25; q[3] = 8'h4C;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap%0d_head", i), evt_word(), mk(1'b1, 1'b0, 1'b0, q[i]));
            evt_ready = 1'b1;
            @(negedge ck);
            evt_ready = 1'b0;
        end
        check("wrap_empty", 32'(evt_count), 32'd0);
        check("ovf_sticky", {31'd0, ovf}, 32'd1);

        // Reset mid-sequence with a stalled FIFO and a byte strobed during reset
        send_byte(8'h33);
        send_byte(8'hF0);
        @(negedge ck);
        reset = 1'b1; in_byte = 8'h2C; in_valid = 1'b1;
        @(negedge ck);
        reset = 1'b0; in_valid = 1'b0;
        check("rst_count", 32'(evt_count), 32'd0);
        check("rst_evt", evt_word(), mk(1'b0, 1'b0, 1'b0, 8'h00));
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        send_byte(8'h1C);
        check("rst_first_evt", evt_word(), mk(1'b1, 1'b0, 1'b0, 8'h1C));
        evt_ready = 1'b1;
        send_byte(8'hE0);
        @(negedge ck);
        reset = 1'b1;
        @(negedge ck);
        reset = 1'b0;
        send_byte(8'h75);
        check("rst_ext_discard", evt_word(), mk(1'b1, 1'b0, 1'b0, 8'h75));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
